// File: rtl/demultiplexer1to2_buffered.sv
// 1-to-2 demultiplexer with a small FIFO per output channel.
// Each beat is routed either to the channel given by `selection` or, in
// auto-alternate mode, to the channel held in `next_channel`, which flips
// after every accepted beat.
module demultiplexer1to2_buffered #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         input_signal,
  input  logic                     input_valid,
  output logic                     input_ready,
  input  logic                     selection,
  input  logic                     auto_alternate,
  output logic [WIDTH-1:0]         output_signal0,
  output logic [WIDTH-1:0]         output_signal1,
  output logic                     output_valid0,
  output logic                     output_valid1,
  input  logic                     output_ready0,
  input  logic                     output_ready1,
  output logic                     next_channel,
  output logic [$clog2(DEPTH):0]   level0,
  output logic [$clog2(DEPTH):0]   level1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  // Per-channel storage and pointers; index 0/1 is the channel number.
  logic [WIDTH-1:0]     r_mem [2][DEPTH];
  logic [1:0][AW-1:0]   r_wptr;
  logic [1:0][AW-1:0]   r_rptr;
  logic [1:0][LW-1:0]   r_level;
  logic                 r_next_channel;

  logic                 w_dest;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic [1:0]           w_full;
  logic [1:0]           w_valid;
  logic [1:0]           w_push;
  logic [1:0]           w_pop;

  // Destination select, handshake decode and per-channel push/pop strobes.
  always_comb begin
    w_dest = auto_alternate ? r_next_channel : selection;
    for (int k = 0; k < 2; k++) begin
      w_full[k]  = (r_level[k] == FullLevel);
      w_valid[k] = (r_level[k] != '0);
    end
    // A full destination blocks the push even if it is popped this cycle.
    w_in_ready = !reset && !w_full[w_dest];
    w_in_fire  = input_valid && w_in_ready;
    w_push         = '0;
    w_push[w_dest] = w_in_fire;
    w_pop = w_valid & {output_ready1, output_ready0};
  end

  // Pointer, occupancy and alternation state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_next_channel <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + AW'(1);
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + AW'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_level[k] <= r_level[k] + LW'(1);
          2'b01:   r_level[k] <= r_level[k] - LW'(1);
          default: r_level[k] <= r_level[k];
        endcase
      end
      if (w_in_fire && auto_alternate) r_next_channel <= ~r_next_channel;
    end
  end

  // FIFO storage write; contents are don't-care while empty so no reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (w_push[k]) r_mem[k][r_wptr[k]] <= input_signal;
    end
  end

  // Outputs come straight from registered state; empty channels show zero.
  always_comb begin
    input_ready    = w_in_ready;
    next_channel   = r_next_channel;
    output_valid0  = w_valid[0];
    output_valid1  = w_valid[1];
    output_signal0 = w_valid[0] ? r_mem[0][r_rptr[0]] : '0;
    output_signal1 = w_valid[1] ? r_mem[1][r_rptr[1]] : '0;
    level0         = r_level[0];
    level1         = r_level[1];
  end

endmodule

// File: doc/demultiplexer1to2_buffered.md
DEMULTIPLEXER1TO2_BUFFERED -- requirements
Module: demultiplexer1to2_buffered

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every data beat.
REQ-002 Parameter DEPTH, default 4: entries per output-channel FIFO; SHALL be a power of two, at least 2.
REQ-003 Port clock  input  1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1: reset is synchronous and active-high.
REQ-005 Port input_signal  input  WIDTH: data beat to be routed.
REQ-006 Port input_valid  input  1: input_signal holds a beat.
REQ-007 Port input_ready  output  1: block accepts the beat this cycle.
REQ-008 Port selection  input  1: destination channel, 0 or 1, used when auto_alternate=0.
REQ-009 Port auto_alternate  input  1: 1 = destination taken from next_channel instead of selection.
REQ-010 Port output_signal0 / output_signal1  output  WIDTH: head-of-FIFO data for channel 0 / 1.
REQ-011 Port output_valid0 / output_valid1  output  1: channel FIFO is non-empty.
REQ-012 Port output_ready0 / output_ready1  input  1: downstream consumes the head beat.
REQ-013 Port next_channel  output  1: destination for the next beat in auto_alternate mode.
REQ-014 Port level0 / level1  output  log2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

Function
REQ-015 Destination dest SHALL be next_channel when auto_alternate=1, else selection, evaluated combinationally in the same cycle.
REQ-016 input_ready SHALL be 1 exactly when reset=0 and level of FIFO dest is less than DEPTH; it SHALL NOT depend on input_valid.
REQ-017 An input transfer occurs when input_valid=1 and input_ready=1; the beat SHALL be written to the tail of FIFO dest at that edge.
REQ-018 Output transfer on channel k occurs when output_valid_k=1 and output_ready_k=1; the head entry SHALL be removed at that edge.
REQ-019 output_valid_k SHALL equal (level_k != 0); output_signal_k SHALL equal the head entry when valid and all-zeros when empty.
REQ-020 Latency: a beat accepted at edge N into an empty FIFO SHALL appear on output_signal_k with output_valid_k=1 in the cycle after edge N; no combinational input-to-output path.
REQ-021 Ordering: each channel SHALL deliver beats in acceptance order; no beat dropped, duplicated or routed to the other channel.
REQ-022 While output_valid_k=1 and output_ready_k=0, output_signal_k SHALL hold stable.
REQ-023 Simultaneous push and pop on the same channel SHALL leave level_k unchanged and preserve order, including at level DEPTH-1 and level 1.
REQ-024 Full FIFO: push SHALL NOT occur (input_ready=0 for that dest) even if a pop occurs in the same cycle; the other channel remains independently usable.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH without loss of data.
REQ-026 next_channel SHALL toggle at each input transfer while auto_alternate=1 and otherwise hold; toggling auto_alternate SHALL NOT change next_channel by itself.
REQ-027 output_ready_k asserted while channel k is empty SHALL have no effect.

Reset
REQ-028 When reset=1 at an edge: level0=level1=0, both FIFOs empty, output_valid0/1=0, output_signal0/1=0, next_channel=0; FIFO storage contents need not be cleared.
REQ-029 During reset=1, input_ready SHALL be 0; beats presented are discarded.
REQ-030 Reset asserted mid-operation SHALL discard all buffered beats; first accepted beat after reset SHALL go to channel 0 in auto_alternate mode.

Verification
REQ-031 auto_alternate=0, selection=1, push 8'hA5 into empty block, output_ready1=0 -> cycle after: output_valid1=1, output_signal1=8'hA5, level1=1, output_valid0=0.
REQ-032 auto_alternate=1, push 8'h01..8'h04 back-to-back, both outputs not ready -> channel 0 holds 01,03; channel 1 holds 02,04; next_channel=0.
REQ-033 selection=0, push 8'h10..8'h13 with output_ready0=0 -> level0=4, input_ready=0 for dest 0; switch selection=1 -> input_ready=1.
REQ-034 Channel 0 full, output_ready0=1 and input_valid=1 dest 0 same cycle -> pop only, level0=3; next cycle push accepted, level0 stays 3 with continuous pop.
REQ-035 Stream 20 beats to channel 0 with output_ready0 toggling randomly -> output sequence exactly matches input, pointer wrap exercised.
REQ-036 Three beats buffered, auto_alternate=1, then reset=1 one cycle -> level0=level1=0, valids 0, next_channel=0, input_ready=0 during reset.
